// File: rtl/l1_lc_arb_pkg.sv
// l1_lc_arb_pkg: shared types and default sizes for the L1 -> LC arbiter.
//   lc_req_t   : one request toward the LC (line address, write data, write flag).
//   ot_entry_t : one outstanding-read table entry (valid, line address, issuing client).
// The struct widths follow the package defaults; the top-level parameters
// default to the same values and must stay consistent with them.
package l1_lc_arb_pkg;

  localparam int N_DEF           = 2;
  localparam int PADDR_BITS_DEF  = 22;
  localparam int LINE_BITS_DEF   = 512;
  localparam int OUTSTANDING_DEF = 4;
  // Client id width; covers N_DEF clients (port 0 = L1D, port 1 = L1I).
  localparam int ID_BITS         = 1;

  typedef struct packed {
    logic [PADDR_BITS_DEF-1:0] addr;
    logic [LINE_BITS_DEF-1:0]  value;
    logic                      we;
  } lc_req_t;

  typedef struct packed {
    logic                      valid;
    logic [PADDR_BITS_DEF-1:0] addr;
    logic [ID_BITS-1:0]        id;
  } ot_entry_t;

endpackage

// File: rtl/l1_lc_arbiter_table.sv
// lc_outstanding_table: address-tagged table of line reads waiting for an LC fill.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   alloc_i/_addr_i/_id_i    allocate lowest free entry (ignored when full)
//   lookup_i, lookup_addr_i  CAM lookup of a fill address; a hit frees the entry
//   lookup_hit_o/_id_o       lookup result and the issuing client of the hit
//   chk_addr_i, chk_hit_o    per-client "address already outstanding" check
//   full_o, count_o          table full flag, number of live entries
// All checks look at the pre-edge table, so an entry freed this cycle becomes
// allocatable only in the next cycle.
module lc_outstanding_table
  import l1_lc_arb_pkg::*;
#(
  parameter int DEPTH = OUTSTANDING_DEF,
  parameter int NCHK  = N_DEF,
  parameter int CW    = $clog2(OUTSTANDING_DEF + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           alloc_i,
  input  logic [PADDR_BITS_DEF-1:0]      alloc_addr_i,
  input  logic [ID_BITS-1:0]             alloc_id_i,
  input  logic                           lookup_i,
  input  logic [PADDR_BITS_DEF-1:0]      lookup_addr_i,
  output logic                           lookup_hit_o,
  output logic [ID_BITS-1:0]             lookup_id_o,
  input  logic [NCHK*PADDR_BITS_DEF-1:0] chk_addr_i,
  output logic [NCHK-1:0]                chk_hit_o,
  output logic                           full_o,
  output logic [CW-1:0]                  count_o
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ot_entry_t       entries_q [DEPTH];
  ot_entry_t       entries_d [DEPTH];
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic [IDXW-1:0] free_idx;
  logic [IDXW-1:0] hit_idx;
  logic            alloc_now;
  logic            free_now;

  // Fill-address CAM; iterating downward leaves the lowest matching entry selected.
  always_comb begin
    lookup_hit_o = 1'b0;
    lookup_id_o  = '0;
    hit_idx      = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (entries_q[e].valid && (entries_q[e].addr == lookup_addr_i)) begin
        lookup_hit_o = 1'b1;
        lookup_id_o  = entries_q[e].id;
        hit_idx      = IDXW'(e);
      end else begin
        lookup_hit_o = lookup_hit_o;
      end
    end
  end

  // Per-client address-hit check used to hold back duplicate reads.
  always_comb begin
    chk_hit_o = '0;
    for (int c = 0; c < NCHK; c++) begin
      for (int e = 0; e < DEPTH; e++) begin
        chk_hit_o[c] = chk_hit_o[c] |
          (entries_q[e].valid &&
           (entries_q[e].addr == chk_addr_i[c*PADDR_BITS_DEF +: PADDR_BITS_DEF]));
      end
    end
  end

  // Lowest free entry and full flag.
  always_comb begin
    free_idx = '0;
    full_o   = 1'b1;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      free_idx = entries_q[e].valid ? free_idx : IDXW'(e);
      full_o   = full_o & entries_q[e].valid;
    end
  end

  // Next table state: allocation and free never target the same entry
  // (the free index is invalid, the hit index is valid).
  always_comb begin
    alloc_now = alloc_i & ~full_o;
    free_now  = lookup_i & lookup_hit_o;
    for (int e = 0; e < DEPTH; e++) begin
      if (alloc_now && (free_idx == IDXW'(e))) begin
        entries_d[e] = '{valid: 1'b1, addr: alloc_addr_i, id: alloc_id_i};
      end else if (free_now && (hit_idx == IDXW'(e))) begin
        entries_d[e] = '{valid: 1'b0, addr: entries_q[e].addr, id: entries_q[e].id};
      end else begin
        entries_d[e] = entries_q[e];
      end
    end
    count_d = count_q + CW'(alloc_now) - CW'(free_now);
  end

  // Table and live-entry count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int e = 0; e < DEPTH; e++) begin
        entries_q[e] <= '0;
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/l1_lc_arbiter.sv
// l1_lc_arbiter: shares the single LC request/fill port between N L1 clients
// (port 0 = L1D, port 1 = L1I). Round-robin grant into a one-entry request
// register toward the LC; outstanding reads tracked in lc_outstanding_table;
// each LC fill is captured into a one-entry fill register and routed back to
// the client that issued the read.
// Ports (client i uses slice [i*W +: W] of every flattened bus):
//   clk_in, rst_N_in                       clock, asynchronous active-low reset
//   up_valid_in/up_ready_out/up_addr_in/
//   up_value_in/up_we_in                   client requests
//   up_valid_out/up_ready_in/up_addr_out/
//   up_value_out                           fills toward clients (addr/data shared)
//   lc_valid_out/lc_ready_in/lc_addr_out/
//   lc_value_out/lc_we_out                 requests toward the LC
//   lc_valid_in/lc_ready_out/lc_addr_in/
//   lc_value_in                            fills from the LC
//   outstanding_out                        live table entries
//   unmatched_out                          pulse: a fill matched no entry
module l1_lc_arbiter
  import l1_lc_arb_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int PADDR_BITS  = PADDR_BITS_DEF,
  parameter int LINE_BITS   = LINE_BITS_DEF,
  parameter int OUTSTANDING = OUTSTANDING_DEF
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic [N-1:0]                         up_valid_in,
  output logic [N-1:0]                         up_ready_out,
  input  logic [N*PADDR_BITS-1:0]              up_addr_in,
  input  logic [N*LINE_BITS-1:0]               up_value_in,
  input  logic [N-1:0]                         up_we_in,
  output logic [N-1:0]                         up_valid_out,
  input  logic [N-1:0]                         up_ready_in,
  output logic [PADDR_BITS-1:0]                up_addr_out,
  output logic [LINE_BITS-1:0]                 up_value_out,
  output logic                                 lc_valid_out,
  input  logic                                 lc_ready_in,
  output logic [PADDR_BITS-1:0]                lc_addr_out,
  output logic [LINE_BITS-1:0]                 lc_value_out,
  output logic                                 lc_we_out,
  input  logic                                 lc_valid_in,
  output logic                                 lc_ready_out,
  input  logic [PADDR_BITS-1:0]                lc_addr_in,
  input  logic [LINE_BITS-1:0]                 lc_value_in,
  output logic [$clog2(OUTSTANDING+1)-1:0]     outstanding_out,
  output logic                                 unmatched_out
);

  localparam int CW = $clog2(OUTSTANDING + 1);

  lc_req_t              req_q;
  lc_req_t              req_d;
  logic                 req_valid_q;
  logic                 req_valid_d;
  logic [ID_BITS-1:0]   prio_q;
  logic [ID_BITS-1:0]   prio_d;
  logic                 fill_valid_q;
  logic                 fill_valid_d;
  logic [PADDR_BITS-1:0] fill_addr_q;
  logic [PADDR_BITS-1:0] fill_addr_d;
  logic [LINE_BITS-1:0] fill_value_q;
  logic [LINE_BITS-1:0] fill_value_d;
  logic [ID_BITS-1:0]   fill_id_q;
  logic [ID_BITS-1:0]   fill_id_d;
  logic                 unmatched_q;
  logic                 unmatched_d;

  logic [N-1:0]          elig;
  logic                  can_accept;
  logic                  gnt_any;
  logic [ID_BITS-1:0]    gnt_idx;
  logic [ID_BITS-1:0]    cand;
  logic                  gnt_we;
  logic [PADDR_BITS-1:0] gnt_addr;
  logic [LINE_BITS-1:0]  gnt_value;
  logic                  fill_drain;
  logic                  capture;

  logic                  tbl_full;
  logic [N-1:0]          tbl_chk_hit;
  logic                  tbl_hit;
  logic [ID_BITS-1:0]    tbl_id;
  logic [CW-1:0]         tbl_count;

  lc_outstanding_table #(
    .DEPTH (OUTSTANDING),
    .NCHK  (N),
    .CW    (CW)
  ) u_table (
    .clk_i         (clk_in),
    .rst_ni        (rst_N_in),
    .alloc_i       (gnt_any & ~gnt_we),
    .alloc_addr_i  (gnt_addr),
    .alloc_id_i    (gnt_idx),
    .lookup_i      (capture),
    .lookup_addr_i (lc_addr_in),
    .lookup_hit_o  (tbl_hit),
    .lookup_id_o   (tbl_id),
    .chk_addr_i    (up_addr_in),
    .chk_hit_o     (tbl_chk_hit),
    .full_o        (tbl_full),
    .count_o       (tbl_count)
  );

  // Eligibility: writes bypass the table; reads need a free entry and no live duplicate.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i] = up_valid_in[i] & (up_we_in[i] | (~tbl_full & ~tbl_chk_hit[i]));
    end
    can_accept = ~req_valid_q | lc_ready_in;
  end

  // Round-robin pick; scanning from the far end lets the client nearest prio_q win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand    = ID_BITS'((int'(prio_q) + k) % N);
      gnt_any = gnt_any | (can_accept & elig[cand]);
      gnt_idx = (can_accept & elig[cand]) ? cand : gnt_idx;
    end
    gnt_we    = up_we_in[gnt_idx];
    gnt_addr  = up_addr_in[int'(gnt_idx)*PADDR_BITS +: PADDR_BITS];
    gnt_value = up_value_in[int'(gnt_idx)*LINE_BITS +: LINE_BITS];
  end

  // Request register and round-robin pointer next state.
  always_comb begin
    if (gnt_any) begin
      req_valid_d = 1'b1;
      req_d       = '{addr: gnt_addr, value: gnt_value, we: gnt_we};
      prio_d      = ID_BITS'((int'(gnt_idx) + 1) % N);
    end else if (lc_ready_in) begin
      req_valid_d = 1'b0;
      req_d       = req_q;
      prio_d      = prio_q;
    end else begin
      req_valid_d = req_valid_q;
      req_d       = req_q;
      prio_d      = prio_q;
    end
  end

  // Fill register next state; a miss is dropped and flagged.
  always_comb begin
    fill_drain   = fill_valid_q & up_ready_in[fill_id_q];
    capture      = lc_valid_in & (~fill_valid_q | fill_drain);
    unmatched_d  = capture & ~tbl_hit;
    if (capture && tbl_hit) begin
      fill_valid_d = 1'b1;
      fill_addr_d  = lc_addr_in;
      fill_value_d = lc_value_in;
      fill_id_d    = tbl_id;
    end else if (fill_drain) begin
      fill_valid_d = 1'b0;
      fill_addr_d  = fill_addr_q;
      fill_value_d = fill_value_q;
      fill_id_d    = fill_id_q;
    end else begin
      fill_valid_d = fill_valid_q;
      fill_addr_d  = fill_addr_q;
      fill_value_d = fill_value_q;
      fill_id_d    = fill_id_q;
    end
  end

  // Request, pointer and fill registers.
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      req_q        <= '0;
      req_valid_q  <= 1'b0;
      prio_q       <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_value_q <= '0;
      fill_id_q    <= '0;
      unmatched_q  <= 1'b0;
    end else begin
      req_q        <= req_d;
      req_valid_q  <= req_valid_d;
      prio_q       <= prio_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_value_q <= fill_value_d;
      fill_id_q    <= fill_id_d;
      unmatched_q  <= unmatched_d;
    end
  end

  assign up_ready_out    = gnt_any ? (N'(1) << gnt_idx) : '0;
  assign lc_ready_out    = ~fill_valid_q | fill_drain;
  assign lc_valid_out    = req_valid_q;
  assign lc_addr_out     = req_q.addr;
  assign lc_value_out    = req_q.value;
  assign lc_we_out       = req_q.we;
  assign up_valid_out    = fill_valid_q ? (N'(1) << fill_id_q) : '0;
  assign up_addr_out     = fill_addr_q;
  assign up_value_out    = fill_value_q;
  assign outstanding_out = tbl_count;
  assign unmatched_out   = unmatched_q;

endmodule

// File: tb/tb_l1_lc_arbiter.sv
module tb_l1_lc_arbiter;

  localparam int N  = 2;
  localparam int PA = 22;
  localparam int LB = 512;
  localparam int OT = 4;

  typedef struct {
    logic [PA-1:0] addr;
    logic [LB-1:0] value;
    logic          we;
  } req_exp_t;

  typedef struct {
    logic [N-1:0]  vec;
    logic [PA-1:0] addr;
    logic [LB-1:0] value;
  } fill_exp_t;

  logic            clk_in = 1'b0;
  logic            rst_N_in;
  logic [N-1:0]    up_valid_in;
  logic [N-1:0]    up_ready_out;
  logic [N*PA-1:0] up_addr_in;
  logic [N*LB-1:0] up_value_in;
  logic [N-1:0]    up_we_in;
  logic [N-1:0]    up_valid_out;
  logic [N-1:0]    up_ready_in;
  logic [PA-1:0]   up_addr_out;
  logic [LB-1:0]   up_value_out;
  logic            lc_valid_out;
  logic            lc_ready_in;
  logic [PA-1:0]   lc_addr_out;
  logic [LB-1:0]   lc_value_out;
  logic            lc_we_out;
  logic            lc_valid_in;
  logic            lc_ready_out;
  logic [PA-1:0]   lc_addr_in;
  logic [LB-1:0]   lc_value_in;
  logic [2:0]      outstanding_out;
  logic            unmatched_out;

  int vectors = 0;
  int miscompares = 0;
  req_exp_t  exp_req[$];
  fill_exp_t exp_fill[$];
  req_exp_t  mon_req;
  fill_exp_t mon_fill;

  l1_lc_arbiter #(.N(N), .PADDR_BITS(PA), .LINE_BITS(LB), .OUTSTANDING(OT)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .up_valid_in(up_valid_in), .up_ready_out(up_ready_out), .up_addr_in(up_addr_in),
    .up_value_in(up_value_in), .up_we_in(up_we_in),
    .up_valid_out(up_valid_out), .up_ready_in(up_ready_in), .up_addr_out(up_addr_out),
    .up_value_out(up_value_out),
    .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in), .lc_addr_out(lc_addr_out),
    .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
    .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out), .lc_addr_in(lc_addr_in),
    .lc_value_in(lc_value_in),
    .outstanding_out(outstanding_out), .unmatched_out(unmatched_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic check_line(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int c, input logic v, input logic [PA-1:0] a,
                         input logic we, input logic [LB-1:0] val);
    up_valid_in[c]          = v;
    up_addr_in[c*PA +: PA]  = a;
    up_we_in[c]             = we;
    up_value_in[c*LB +: LB] = val;
  endtask

  task automatic push_req(input logic [PA-1:0] a, input logic we, input logic [LB-1:0] val);
    req_exp_t r;
    r.addr = a; r.we = we; r.value = val;
    exp_req.push_back(r);
  endtask

  task automatic push_fill(input logic [N-1:0] vec, input logic [PA-1:0] a, input logic [LB-1:0] val);
    fill_exp_t f;
    f.vec = vec; f.addr = a; f.value = val;
    exp_fill.push_back(f);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_fill(input logic [PA-1:0] a, input logic [LB-1:0] val);
    lc_valid_in = 1'b1;
    lc_addr_in  = a;
    lc_value_in = val;
  endtask

  // Scoreboard monitor: pops expectations on each LC request and client fill handshake.
  always @(negedge clk_in) begin
    if (rst_N_in === 1'b1) begin
      if (lc_valid_out && lc_ready_in) begin
        vectors++;
        assert (exp_req.size() != 0) else begin
          miscompares++;
          $error("FAIL lc_req_unexpected: observed addr 0x%0h expected none", lc_addr_out);
        end
        if (exp_req.size() != 0) begin
          mon_req = exp_req.pop_front();
          check("lc_addr", 64'(lc_addr_out), 64'(mon_req.addr));
          check("lc_we", 64'(lc_we_out), 64'(mon_req.we));
          check_line("lc_value", lc_value_out, mon_req.value);
        end
      end
      if ((up_valid_out & up_ready_in) != 2'b00) begin
        vectors++;
        assert (exp_fill.size() != 0) else begin
          miscompares++;
          $error("FAIL fill_unexpected: observed vec %b expected none", up_valid_out);
        end
        if (exp_fill.size() != 0) begin
          mon_fill = exp_fill.pop_front();
          check("fill_vec", 64'(up_valid_out), 64'(mon_fill.vec));
          check("fill_addr", 64'(up_addr_out), 64'(mon_fill.addr));
          check_line("fill_value", up_value_out, mon_fill.value);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [PA-1:0] rr_addr [2];
  logic [PA-1:0] ft_addrs [4];

  initial begin
    rst_N_in    = 1'b0;
    up_valid_in = '0;
    up_addr_in  = '0;
    up_value_in = '0;
    up_we_in    = '0;
    up_ready_in = 2'b11;
    lc_ready_in = 1'b1;
    lc_valid_in = 1'b0;
    lc_addr_in  = '0;
    lc_value_in = '0;
    step();
    step();
    // Reset state
    check("rst_up_ready", 64'(up_ready_out), 64'd0);
    check("rst_up_valid", 64'(up_valid_out), 64'd0);
    check("rst_lc_valid", 64'(lc_valid_out), 64'd0);
    check("rst_unmatched", 64'(unmatched_out), 64'd0);
    check("rst_lc_ready", 64'(lc_ready_out), 64'd1);
    check("rst_count", 64'(outstanding_out), 64'd0);
    check("rst_lc_addr", 64'(lc_addr_out), 64'd0);
    check_line("rst_up_value", up_value_out, '0);
    rst_N_in = 1'b1;
    step();

    // Round-robin: both clients keep reading; each advances its address once granted
    rr_addr[0] = 22'h00100;
    rr_addr[1] = 22'h00200;
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, rr_addr[0], 1'b0, 512'(64'hA0 + k));
      set_req(1, 1'b1, rr_addr[1], 1'b0, 512'(64'hB0 + k));
      settle();
      check("rr_grant", 64'(up_ready_out), (k % 2 == 0) ? 64'd1 : 64'd2);
      push_req(rr_addr[k % 2], 1'b0, (k % 2 == 0) ? 512'(64'hA0 + k) : 512'(64'hB0 + k));
      rr_addr[k % 2] = rr_addr[k % 2] + 22'd1;
      step();
    end
    up_valid_in = '0;
    settle();
    check("rr_count", 64'(outstanding_out), 64'd4);
    // Fill in a scrambled order; each routes to its issuer
    ft_addrs[0] = 22'h00201; ft_addrs[1] = 22'h00100;
    ft_addrs[2] = 22'h00200; ft_addrs[3] = 22'h00101;
    for (int k = 0; k < 4; k++) begin
      drive_fill(ft_addrs[k], 512'(64'hF00 + k));
      settle();
      check("rr_fill_ready", 64'(lc_ready_out), 64'd1);
      push_fill(ft_addrs[k][9:8] == 2'b10 ? 2'b10 : 2'b01, ft_addrs[k], 512'(64'hF00 + k));
      step();
    end
    lc_valid_in = 1'b0;
    settle();
    check("rr_count_empty", 64'(outstanding_out), 64'd0);
    step();

    // Single read from L1D
    set_req(0, 1'b1, 22'h01806, 1'b0, 512'h0);
    settle();
    check("single_grant", 64'(up_ready_out), 64'd1);
    push_req(22'h01806, 1'b0, 512'h0);
    step();
    up_valid_in = '0;
    settle();
    check("single_lc_valid", 64'(lc_valid_out), 64'd1);
    check("single_lc_addr", 64'(lc_addr_out), 64'h01806);
    check("single_count", 64'(outstanding_out), 64'd1);
    step();
    drive_fill(22'h01806, 512'hDEADBEEF);
    push_fill(2'b01, 22'h01806, 512'hDEADBEEF);
    step();
    lc_valid_in = 1'b0;
    settle();
    check("single_up_valid", 64'(up_valid_out), 64'd1);
    check_line("single_up_value", up_value_out, 512'hDEADBEEF);
    check("single_count0", 64'(outstanding_out), 64'd0);
    step();
    check("single_up_valid_off", 64'(up_valid_out), 64'd0);

    // Full table: four reads with no LC response
    for (int k = 0; k < 4; k++) begin
      set_req(0, 1'b1, 22'h00400 + 22'(k), 1'b0, 512'h0);
      settle();
      check("full_grant", 64'(up_ready_out), 64'd1);
      push_req(22'h00400 + 22'(k), 1'b0, 512'h0);
      step();
    end
    set_req(0, 1'b1, 22'h00404, 1'b0, 512'h0);
    set_req(1, 1'b1, 22'h00300, 1'b1, 512'h5A5A_1234);
    settle();
    check("full_write_granted", 64'(up_ready_out), 64'd2);
    check("full_count", 64'(outstanding_out), 64'd4);
    push_req(22'h00300, 1'b1, 512'h5A5A_1234);
    step();
    up_valid_in[1] = 1'b0;
    drive_fill(22'h00402, 512'h402);
    settle();
    check("full_read_stalled", 64'(up_ready_out), 64'd0);
    push_fill(2'b01, 22'h00402, 512'h402);
    step();
    lc_valid_in = 1'b0;
    settle();
    check("full_count_freed", 64'(outstanding_out), 64'd3);
    check("full_5th_granted", 64'(up_ready_out), 64'd1);
    push_req(22'h00404, 1'b0, 512'h0);
    step();
    up_valid_in = '0;
    settle();
    check("full_count_again", 64'(outstanding_out), 64'd4);
    ft_addrs[0] = 22'h00400; ft_addrs[1] = 22'h00401;
    ft_addrs[2] = 22'h00403; ft_addrs[3] = 22'h00404;
    for (int k = 0; k < 4; k++) begin
      drive_fill(ft_addrs[k], 512'(ft_addrs[k]));
      push_fill(2'b01, ft_addrs[k], 512'(ft_addrs[k]));
      step();
    end
    lc_valid_in = 1'b0;
    settle();
    check("full_drained", 64'(outstanding_out), 64'd0);
    step();

    // Duplicate address: L1I waits for L1D's outstanding read of the same line
    set_req(0, 1'b1, 22'h00080, 1'b0, 512'h0);
    settle();
    check("dup_d_grant", 64'(up_ready_out), 64'd1);
    push_req(22'h00080, 1'b0, 512'h0);
    step();
    up_valid_in[0] = 1'b0;
    set_req(1, 1'b1, 22'h00080, 1'b0, 512'h11);
    settle();
    check("dup_i_stall0", 64'(up_ready_out), 64'd0);
    step();
    check("dup_i_stall1", 64'(up_ready_out), 64'd0);
    drive_fill(22'h00080, 512'hAAAA);
    settle();
    check("dup_i_stall_fill", 64'(up_ready_out), 64'd0);
    push_fill(2'b01, 22'h00080, 512'hAAAA);
    step();
    lc_valid_in = 1'b0;
    settle();
    check("dup_i_grant", 64'(up_ready_out), 64'd2);
    check("dup_d_fill", 64'(up_valid_out), 64'd1);
    push_req(22'h00080, 1'b0, 512'h11);
    step();
    up_valid_in = '0;
    drive_fill(22'h00080, 512'hBBBB);
    push_fill(2'b10, 22'h00080, 512'hBBBB);
    step();
    lc_valid_in = 1'b0;
    settle();
    check("dup_i_fill", 64'(up_valid_out), 64'd2);
    check_line("dup_i_value", up_value_out, 512'hBBBB);
    step();

    // Backpressure on the LC request side, then on the client fill side
    lc_ready_in = 1'b0;
    set_req(0, 1'b1, 22'h00155, 1'b1, 512'hC0FFEE);
    settle();
    check("bp_write_grant", 64'(up_ready_out), 64'd1);
    push_req(22'h00155, 1'b1, 512'hC0FFEE);
    step();
    up_valid_in[0] = 1'b0;
    set_req(1, 1'b1, 22'h00123, 1'b0, 512'h77);
    for (int k = 0; k < 3; k++) begin
      settle();
      check("bp_lc_valid", 64'(lc_valid_out), 64'd1);
      check("bp_lc_addr", 64'(lc_addr_out), 64'h00155);
      check("bp_no_grant", 64'(up_ready_out), 64'd0);
      step();
    end
    lc_ready_in = 1'b1;
    settle();
    check("bp_grant_on_drain", 64'(up_ready_out), 64'd2);
    push_req(22'h00123, 1'b0, 512'h77);
    step();
    up_valid_in = '0;
    up_ready_in = 2'b00;
    drive_fill(22'h00123, 512'h1234_5678);
    settle();
    check("bp_fill_ready", 64'(lc_ready_out), 64'd1);
    push_fill(2'b10, 22'h00123, 512'h1234_5678);
    step();
    lc_valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("bp_up_valid_held", 64'(up_valid_out), 64'd2);
      check("bp_up_addr_held", 64'(up_addr_out), 64'h00123);
      check("bp_lc_ready_low", 64'(lc_ready_out), 64'd0);
      if (k == 0) step();
    end
    up_ready_in = 2'b11;
    settle();
    check("bp_lc_ready_drain", 64'(lc_ready_out), 64'd1);
    step();
    check("bp_up_valid_off", 64'(up_valid_out), 64'd0);

    // Unmatched fill with an empty table
    drive_fill(22'h3FFFF, 512'h99);
    step();
    lc_valid_in = 1'b0;
    settle();
    check("unm_pulse", 64'(unmatched_out), 64'd1);
    check("unm_no_fill", 64'(up_valid_out), 64'd0);
    step();
    check("unm_pulse_end", 64'(unmatched_out), 64'd0);

    // Reset with two reads outstanding
    set_req(0, 1'b1, 22'h00010, 1'b0, 512'h0);
    settle();
    check("rst_rd0_grant", 64'(up_ready_out), 64'd1);
    push_req(22'h00010, 1'b0, 512'h0);
    step();
    set_req(0, 1'b1, 22'h00011, 1'b0, 512'h0);
    settle();
    check("rst_rd1_grant", 64'(up_ready_out), 64'd1);
    push_req(22'h00011, 1'b0, 512'h0);
    step();
    up_valid_in = '0;
    settle();
    check("rst_pre_count", 64'(outstanding_out), 64'd2);
    @(negedge clk_in);
    #1;
    rst_N_in = 1'b0;
    #1;
    check("rst_count_cleared", 64'(outstanding_out), 64'd0);
    check("rst_lc_valid_cleared", 64'(lc_valid_out), 64'd0);
    step();
    rst_N_in = 1'b1;
    step();
    step();
    check("post_rst_count", 64'(outstanding_out), 64'd0);
    check("post_rst_lc_ready", 64'(lc_ready_out), 64'd1);
    check("req_queue_empty", 64'(exp_req.size()), 64'd0);
    check("fill_queue_empty", 64'(exp_fill.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
